// File: rtl/hicore_icb_splitter_pkg.sv
// Shared constants for the HiCore ICB 1-to-3 splitter: target IDs,
// default address map and base widths.
package hicore_icb_splitter_pkg;

  localparam int HiCore_ADDR_SIZE = 32;
  localparam int HiCore_REG_SIZE  = 32;
  localparam int NUM_TGT          = 3;
  localparam int TGT_ID_W         = 2;

  typedef enum logic [TGT_ID_W-1:0] {
    TGT_CLINT = 2'd0,
    TGT_PLIC  = 2'd1,
    TGT_MEM   = 2'd2
  } tgt_e;

  localparam logic [HiCore_ADDR_SIZE-1:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [HiCore_ADDR_SIZE-1:0] DEF_CLINT_MASK = 32'hFFFF_0000;
  localparam logic [HiCore_ADDR_SIZE-1:0] DEF_PLIC_BASE  = 32'h0C00_0000;
  localparam logic [HiCore_ADDR_SIZE-1:0] DEF_PLIC_MASK  = 32'hFC00_0000;

endpackage

// File: rtl/hicore_outs_fifo.sv
// In-order FIFO of outstanding target IDs; count doubles as the splitter's
// outstanding counter.
module hicore_outs_fifo
  import hicore_icb_splitter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [TGT_ID_W-1:0] din,
  input  logic                pop,
  output logic [TGT_ID_W-1:0] dout,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TGT_ID_W-1:0] mem_q [DEPTH];
  logic [TGT_ID_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hicore_icb_splitter.sv
// 1-to-3 ICB splitter (CLINT / PLIC / memory) with in-order response steering.
// Handshake: a transfer happens on a cycle where valid && ready; valid never waits on ready.
module hicore_icb_splitter
  import hicore_icb_splitter_pkg::*;
#(
  parameter int                 ADDR_W     = HiCore_ADDR_SIZE,
  parameter int                 DATA_W     = HiCore_REG_SIZE,
  parameter int                 OUTS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [ADDR_W-1:0]  CLINT_MASK = DEF_CLINT_MASK,
  parameter logic [ADDR_W-1:0]  PLIC_BASE  = DEF_PLIC_BASE,
  parameter logic [ADDR_W-1:0]  PLIC_MASK  = DEF_PLIC_MASK,
  parameter int                 CNT_W      = $clog2(OUTS_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        m_icb_cmd_valid,
  output logic                        m_icb_cmd_ready,
  input  logic                        m_icb_cmd_read,
  input  logic [ADDR_W-1:0]           m_icb_cmd_addr,
  input  logic [DATA_W-1:0]           m_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0]         m_icb_cmd_wmask,
  output logic                        m_icb_rsp_valid,
  input  logic                        m_icb_rsp_ready,
  output logic                        m_icb_rsp_err,
  output logic [DATA_W-1:0]           m_icb_rsp_rdata,
  output logic [NUM_TGT-1:0]          t_icb_cmd_valid,
  input  logic [NUM_TGT-1:0]          t_icb_cmd_ready,
  output logic                        t_icb_cmd_read,
  output logic [ADDR_W-1:0]           t_icb_cmd_addr,
  output logic [DATA_W-1:0]           t_icb_cmd_wdata,
  output logic [DATA_W/8-1:0]         t_icb_cmd_wmask,
  input  logic [NUM_TGT-1:0]          t_icb_rsp_valid,
  output logic [NUM_TGT-1:0]          t_icb_rsp_ready,
  input  logic [NUM_TGT-1:0]          t_icb_rsp_err,
  input  logic [NUM_TGT*DATA_W-1:0]   t_icb_rsp_rdata,
  output logic [CNT_W-1:0]            outs_cnt
);

  tgt_e                cmd_tgt;
  logic                sel0, sel1;
  logic [TGT_ID_W-1:0] head;
  logic                full, empty, push, pop;

  assign t_icb_cmd_read  = m_icb_cmd_read;
  assign t_icb_cmd_addr  = m_icb_cmd_addr;
  assign t_icb_cmd_wdata = m_icb_cmd_wdata;
  assign t_icb_cmd_wmask = m_icb_cmd_wmask;

  assign sel0 = ((m_icb_cmd_addr & CLINT_MASK) == CLINT_BASE);
  assign sel1 = !sel0 && ((m_icb_cmd_addr & PLIC_MASK) == PLIC_BASE);

  always_comb begin
    cmd_tgt = TGT_MEM;
    if (sel0)      cmd_tgt = TGT_CLINT;
    else if (sel1) cmd_tgt = TGT_PLIC;
  end

  // Ready depends only on decode and fill level, never on the response pop.
  always_comb begin
    t_icb_cmd_valid = '0;
    m_icb_cmd_ready = 1'b0;
    case (cmd_tgt)
      TGT_CLINT: begin
        t_icb_cmd_valid[0] = m_icb_cmd_valid & !full;
        m_icb_cmd_ready    = t_icb_cmd_ready[0] & !full;
      end
      TGT_PLIC: begin
        t_icb_cmd_valid[1] = m_icb_cmd_valid & !full;
        m_icb_cmd_ready    = t_icb_cmd_ready[1] & !full;
      end
      default: begin
        t_icb_cmd_valid[2] = m_icb_cmd_valid & !full;
        m_icb_cmd_ready    = t_icb_cmd_ready[2] & !full;
      end
    endcase
  end

  // Only the FIFO head may present a response; everything else stalls.
  always_comb begin
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    m_icb_rsp_rdata = '0;
    t_icb_rsp_ready = '0;
    if (!empty) begin
      case (head)
        2'd0: begin
          m_icb_rsp_valid    = t_icb_rsp_valid[0];
          m_icb_rsp_err      = t_icb_rsp_err[0];
          m_icb_rsp_rdata    = t_icb_rsp_rdata[0*DATA_W +: DATA_W];
          t_icb_rsp_ready[0] = m_icb_rsp_ready;
        end
        2'd1: begin
          m_icb_rsp_valid    = t_icb_rsp_valid[1];
          m_icb_rsp_err      = t_icb_rsp_err[1];
          m_icb_rsp_rdata    = t_icb_rsp_rdata[1*DATA_W +: DATA_W];
          t_icb_rsp_ready[1] = m_icb_rsp_ready;
        end
        default: begin
          m_icb_rsp_valid    = t_icb_rsp_valid[2];
          m_icb_rsp_err      = t_icb_rsp_err[2];
          m_icb_rsp_rdata    = t_icb_rsp_rdata[2*DATA_W +: DATA_W];
          t_icb_rsp_ready[2] = m_icb_rsp_ready;
        end
      endcase
    end
  end

  assign push = m_icb_cmd_valid & m_icb_cmd_ready;
  assign pop  = m_icb_rsp_valid & m_icb_rsp_ready;

  hicore_outs_fifo #(
    .DEPTH (OUTS_DEPTH),
    .CNT_W (CNT_W)
  ) u_outs_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cmd_tgt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outs_cnt)
  );

endmodule

// File: tb/tb_hicore_icb_splitter.sv
// Bench for hicore_icb_splitter: directed scenarios plus a random phase,
// all checked against a queue of outstanding target IDs.
module tb_hicore_icb_splitter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m_cmd_valid, m_cmd_ready, m_cmd_read;
  logic [AW-1:0]   m_cmd_addr;
  logic [DW-1:0]   m_cmd_wdata;
  logic [DW/8-1:0] m_cmd_wmask;
  logic            m_rsp_valid, m_rsp_ready, m_rsp_err;
  logic [DW-1:0]   m_rsp_rdata;
  logic [2:0]      t_cmd_valid, t_cmd_ready;
  logic            t_cmd_read;
  logic [AW-1:0]   t_cmd_addr;
  logic [DW-1:0]   t_cmd_wdata;
  logic [DW/8-1:0] t_cmd_wmask;
  logic [2:0]      t_rsp_valid, t_rsp_ready, t_rsp_err;
  logic [3*DW-1:0] t_rsp_rdata;
  logic [CW-1:0]   outs_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  hicore_icb_splitter #(.OUTS_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_icb_cmd_valid (m_cmd_valid),
    .m_icb_cmd_ready (m_cmd_ready),
    .m_icb_cmd_read  (m_cmd_read),
    .m_icb_cmd_addr  (m_cmd_addr),
    .m_icb_cmd_wdata (m_cmd_wdata),
    .m_icb_cmd_wmask (m_cmd_wmask),
    .m_icb_rsp_valid (m_rsp_valid),
    .m_icb_rsp_ready (m_rsp_ready),
    .m_icb_rsp_err   (m_rsp_err),
    .m_icb_rsp_rdata (m_rsp_rdata),
    .t_icb_cmd_valid (t_cmd_valid),
    .t_icb_cmd_ready (t_cmd_ready),
    .t_icb_cmd_read  (t_cmd_read),
    .t_icb_cmd_addr  (t_cmd_addr),
    .t_icb_cmd_wdata (t_cmd_wdata),
    .t_icb_cmd_wmask (t_cmd_wmask),
    .t_icb_rsp_valid (t_rsp_valid),
    .t_icb_rsp_ready (t_rsp_ready),
    .t_icb_rsp_err   (t_rsp_err),
    .t_icb_rsp_rdata (t_rsp_rdata),
    .outs_cnt        (outs_cnt)
  );

  function automatic logic [1:0] decode(input logic [AW-1:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0200_0000) return 2'd0;
    if ((a & 32'hFC00_0000) == 32'h0C00_0000) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0200_0000 | AW'($urandom_range(0, 16'hFFFF));
      1:       return 32'h0C00_0000 | ($urandom() & 32'h03FF_FFFF);
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    m_cmd_valid = 1'b0; m_cmd_read = 1'b0; m_cmd_addr = '0;
    m_cmd_wdata = '0; m_cmd_wmask = '0; m_rsp_ready = 1'b0;
    t_cmd_ready = 3'b111; t_rsp_valid = '0; t_rsp_err = '0;
    t_rsp_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  endtask

  task automatic set_cmd(input logic v, input logic rd, input logic [AW-1:0] a);
    m_cmd_valid = v; m_cmd_read = rd; m_cmd_addr = a;
    m_cmd_wdata = $urandom(); m_cmd_wmask = 4'($urandom_range(0, 15));
  endtask

  // One clock: predict outputs from current inputs and the queue, check at
  // the falling edge, then apply the handshakes the model says will happen.
  task automatic step();
    logic [1:0]    tgt, head;
    logic          full, empty, e_cready, e_rvalid;
    logic [2:0]    e_tcv, e_trr;
    logic [DW-1:0] e_rdata;
    tgt      = decode(m_cmd_addr);
    full     = (exp_q.size() == DEPTH);
    empty    = (exp_q.size() == 0);
    head     = empty ? 2'd0 : exp_q[0];
    e_tcv    = (m_cmd_valid && !full) ? (3'b001 << tgt) : 3'b000;
    e_cready = t_cmd_ready[tgt] && !full;
    e_rvalid = !empty && t_rsp_valid[head];
    e_trr    = (!empty && m_rsp_ready) ? (3'b001 << head) : 3'b000;
    e_rdata  = t_rsp_rdata[head*DW +: DW];
    @(negedge clk);
    chk("outs_cnt", 96'(outs_cnt), 96'(exp_q.size()));
    chk("t_cmd_valid", 96'(t_cmd_valid), 96'(e_tcv));
    chk("m_cmd_ready", 96'(m_cmd_ready), 96'(e_cready));
    chk("t_cmd_bcast", {t_cmd_read, t_cmd_addr, t_cmd_wdata, t_cmd_wmask},
        {m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask});
    chk("m_rsp_valid", 96'(m_rsp_valid), 96'(e_rvalid));
    chk("t_rsp_ready", 96'(t_rsp_ready), 96'(e_trr));
    if (e_rvalid) begin
      chk("m_rsp_rdata", 96'(m_rsp_rdata), 96'(e_rdata));
      chk("m_rsp_err", 96'(m_rsp_err), 96'(t_rsp_err[head]));
    end
    @(posedge clk);
    if (e_rvalid && m_rsp_ready) void'(exp_q.pop_front());
    if (m_cmd_valid && e_cready) exp_q.push_back(tgt);
    #1;
  endtask

  task automatic drain();
    int guard;
    set_cmd(1'b0, 1'b0, '0);
    t_rsp_valid = 3'b111; m_rsp_ready = 1'b1; t_rsp_err = '0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("drain_done", 96'(exp_q.size()), 96'(0));
    drive_idle();
  endtask

  initial begin
    drive_idle();
    #1;
    chk("rst_outs_cnt", 96'(outs_cnt), 96'(0));
    chk("rst_m_rsp_valid", 96'(m_rsp_valid), 96'(0));
    chk("rst_t_rsp_ready", 96'(t_rsp_ready), 96'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // CLINT read with single-cycle response
    set_cmd(1'b1, 1'b1, 32'h0200_BFF8);
    step();
    chk("clint_cnt_1", 96'(outs_cnt), 96'(1));
    set_cmd(1'b0, 1'b0, '0);
    t_rsp_rdata[0 +: DW] = 32'h0000_1234;
    t_rsp_valid = 3'b001; m_rsp_ready = 1'b1;
    #1 chk("clint_rdata", 96'(m_rsp_rdata), 96'h1234);
    step();
    chk("clint_cnt_0", 96'(outs_cnt), 96'(0));
    drive_idle();

    // writes to PLIC, memory, CLINT; CLINT answers first but must wait
    set_cmd(1'b1, 1'b0, 32'h0C00_0004); step();
    set_cmd(1'b1, 1'b0, 32'h8000_0000); step();
    set_cmd(1'b1, 1'b0, 32'h0200_4000); step();
    set_cmd(1'b0, 1'b0, '0);
    t_rsp_valid = 3'b001; m_rsp_ready = 1'b1;
    repeat (2) step();
    t_rsp_valid = 3'b111;
    repeat (3) step();
    chk("order_empty", 96'(outs_cnt), 96'(0));
    drive_idle();

    // fill with memory commands, then pop while pushing for three laps
    set_cmd(1'b1, 1'b0, 32'h8000_0000);
    repeat (4) step();
    step();
    chk("full_ready", 96'(m_cmd_ready), 96'(0));
    chk("full_cnt", 96'(outs_cnt), 96'(4));
    t_rsp_valid = 3'b100; m_rsp_ready = 1'b1;
    step();
    chk("ready_after_pop", 96'(m_cmd_ready), 96'(1));
    for (int i = 0; i < 12; i++) begin
      set_cmd(1'b1, 1'b0, 32'h8000_0000 + 32'(i));
      step();
    end
    drain();

    // spurious PLIC response with nothing outstanding
    t_rsp_valid = 3'b010; m_rsp_ready = 1'b1;
    repeat (5) step();
    drive_idle();

    // CLINT error passes through
    set_cmd(1'b1, 1'b1, 32'h0200_0010); step();
    set_cmd(1'b0, 1'b0, '0);
    t_rsp_valid = 3'b001; t_rsp_err = 3'b001; m_rsp_ready = 1'b1;
    #1 chk("clint_err", 96'({m_rsp_valid, m_rsp_err}), 96'(2'b11));
    step();
    drive_idle();

    // asynchronous reset with two outstanding
    set_cmd(1'b1, 1'b0, 32'h0C00_0100); step();
    set_cmd(1'b1, 1'b1, 32'h1000_0000); step();
    set_cmd(1'b0, 1'b0, '0);
    t_rsp_valid = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs_cnt", 96'(outs_cnt), 96'(0));
    chk("arst_m_rsp_valid", 96'(m_rsp_valid), 96'(0));
    exp_q.delete();
    drive_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h0200_0020); step();
    chk("post_rst_cnt", 96'(outs_cnt), 96'(1));
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr());
      t_cmd_ready = 3'($urandom_range(0, 7));
      t_rsp_valid = 3'($urandom_range(0, 7));
      t_rsp_err   = 3'($urandom_range(0, 7));
      t_rsp_rdata = {$urandom(), $urandom(), $urandom()};
      m_rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
